// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and data memory.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
`timescale 1ns/1ps
module data_cache_ctrl #(
  parameter int NUM_LINES   = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  cpuAddress,
  input  logic [31:0]  cpuWriteData,
  input  logic         cpuRead,
  input  logic         cpuWrite,
  input  logic         sb,
  output logic [31:0]  cpuReadData,
  output logic         stall,
  output logic [31:0]  memAddress,
  output logic [31:0]  memWriteData,
  output logic         memWrite,
  output logic         memSb,
  input  logic [511:0] memLine,
  output logic [31:0]  hitCount,
  output logic [31:0]  missCount
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 26 - IDX_W;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [15:0][31:0]    r_data [NUM_LINES];
  logic [31:0]          r_rdata;

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [3:0]           w_woff;
  logic [31:0]          w_word;
  logic [31:0]          w_wword;
  logic                 w_hit;
  logic                 w_rd_hit;
  logic                 w_fill_done;

  assign w_idx       = cpuAddress[6+IDX_W-1:6];
  assign w_tag       = cpuAddress[31:6+IDX_W];
  assign w_woff      = cpuAddress[5:2];
  assign w_word      = r_data[w_idx][w_woff];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_hit    = (r_state == S_IDLE) && cpuRead && !cpuWrite && w_hit;
  assign w_fill_done = (r_state == S_FILL) && (r_cnt == LAT);

  // Store data merged into the cached word; sb replaces only the addressed byte lane.
  always_comb begin
    w_wword = cpuWriteData;
    if (sb) begin
      w_wword = w_word;
      w_wword[{cpuAddress[1:0], 3'b000} +: 8] = cpuWriteData[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpuWrite) begin
            r_state <= S_WRITE;
          end else if (cpuRead && !w_hit) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
          end
        end
        S_FILL: begin
          if (r_cnt == LAT) begin
            r_valid[w_idx] <= 1'b1;
            r_state        <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage needs no reset: validity alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= memLine;
    end else if ((r_state == S_WRITE) && w_hit) begin
      r_data[w_idx][w_woff] <= w_wword;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rdata <= '0;
    else if (w_rd_hit) r_rdata <= w_word;
  end

  assign cpuReadData  = w_rd_hit ? w_word : r_rdata;
  assign stall        = (r_state == S_FILL) ||
                        ((r_state == S_IDLE) && (cpuWrite || (cpuRead && !w_hit)));
  assign memWrite     = (r_state == S_WRITE);
  assign memSb        = (r_state == S_WRITE) && sb;
  assign memWriteData = cpuWriteData;

  always_comb begin
    memAddress = {cpuAddress[31:2], 2'b00};
    if (r_state == S_FILL)                memAddress = {cpuAddress[31:6], 6'b0};
    else if ((r_state == S_WRITE) && sb)  memAddress = cpuAddress;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_miss;
  logic        r_held;

  // r_held marks the IDLE cycle right after a fill, where the same request is re-presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits <= '0;
      r_miss <= '0;
      r_held <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (cpuRead || cpuWrite) && !r_held) begin
        if (w_hit) r_hits <= r_hits + 32'd1;
        else       r_miss <= r_miss + 32'd1;
      end
      r_held <= w_fill_done;
    end
  end

  assign hitCount  = r_hits;
  assign missCount = r_miss;
`else
  assign hitCount  = '0;
  assign missCount = '0;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: cold reads, hits, store hit/miss, byte store, conflict, reset aborts.
`timescale 1ns/1ps
module tb_data_cache_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cpuAddress, cpuWriteData;
  logic         cpuRead, cpuWrite, sb;
  logic [31:0]  cpuReadData;
  logic         stall;
  logic [31:0]  memAddress, memWriteData;
  logic         memWrite, memSb;
  logic [511:0] memLine;
  logic [31:0]  hitCount, missCount;

  logic [31:0]  mem [0:4095];
  logic         mem_load;
  int           n_chk = 0;
  int           n_bad = 0;

  data_cache_ctrl #(.NUM_LINES(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuAddress(cpuAddress), .cpuWriteData(cpuWriteData),
    .cpuRead(cpuRead), .cpuWrite(cpuWrite), .sb(sb),
    .cpuReadData(cpuReadData), .stall(stall),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .memSb(memSb), .memLine(memLine),
    .hitCount(hitCount), .missCount(missCount)
  );

  always #5 clk = ~clk;

  // Memory model: 16-word parallel read of the addressed line, write on memWrite.
  always_comb begin
    memLine = '0;
    for (int i = 0; i < 16; i++)
      memLine[32*i +: 32] = mem[{memAddress[13:6], 4'(i)}];
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h0000_0001;
      mem[1]   <= 32'hf000_f002;
      mem[2]   <= 32'h0000_0003;
      mem[3]   <= 32'h0000_0004;
      mem[256] <= 32'hcafe_0001;
    end else if (memWrite) begin
      if (memSb) mem[memAddress[13:2]][{memAddress[1:0], 3'b000} +: 8] <= memWriteData[7:0];
      else       mem[memAddress[13:2]] <= memWriteData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic lw(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input int exp_stall);
    int n = 0;
    cpuAddress = a; cpuRead = 1'b1; cpuWrite = 1'b0; sb = 1'b0;
    @(negedge clk);
    while (stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".stall"}, n, exp_stall);
    chk({tag, ".data"}, cpuReadData, exp_d);
    @(posedge clk); #1;
    cpuRead = 1'b0;
  endtask

  task automatic sw(input string tag, input logic [31:0] a, input logic [31:0] d, input logic isb);
    logic [31:0] ea;
    ea = isb ? a : {a[31:2], 2'b00};
    cpuAddress = a; cpuWriteData = d; sb = isb; cpuWrite = 1'b1; cpuRead = 1'b0;
    @(negedge clk);
    chk({tag, ".stall0"}, stall, 1);
    chk({tag, ".we0"}, memWrite, 0);
    @(negedge clk);
    chk({tag, ".we1"}, memWrite, 1);
    chk({tag, ".stall1"}, stall, 0);
    chk({tag, ".addr"}, memAddress, ea);
    chk({tag, ".wdata"}, memWriteData, d);
    chk({tag, ".sb"}, memSb, isb);
    @(posedge clk); #1;
    cpuWrite = 1'b0; sb = 1'b0;
    @(negedge clk);
    chk({tag, ".we2"}, memWrite, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_load = 1'b1;
    cpuAddress = '0; cpuWriteData = '0; cpuRead = 1'b0; cpuWrite = 1'b0; sb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", stall, 0);
    chk("rst.we", memWrite, 0);
    chk("rst.hits", hitCount, 0);
    chk("rst.miss", missCount, 0);
    mem_load = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    lw("t1", 32'h4, 32'hf000_f002, 3);
    lw("t2", 32'h8, 32'h0000_0003, 0);
`ifdef CACHE_STATS_EN
    chk("t2.hits", hitCount, 1);
    chk("t2.miss", missCount, 1);
`else
    chk("t2.hits", hitCount, 0);
    chk("t2.miss", missCount, 0);
`endif
    @(negedge clk);
    chk("t2.hold", cpuReadData, 32'h0000_0003);
    @(posedge clk); #1;

    sw("t3", 32'hc, 32'hdead_beef, 1'b0);
    lw("t3r", 32'hc, 32'hdead_beef, 0);

    sw("t4", 32'h1, 32'h0000_005a, 1'b1);
    lw("t4r", 32'h0, 32'h0000_5a01, 0);

    lw("t5a", 32'h400, 32'hcafe_0001, 3);
    lw("t5b", 32'h0, 32'h0000_5a01, 3);
    sw("t5c", 32'h2044, 32'h1234_5678, 1'b0);
    lw("t5d", 32'h2044, 32'h1234_5678, 3);
`ifdef CACHE_STATS_EN
    chk("t5.hits", hitCount, 5);
    chk("t5.miss", missCount, 5);
`endif

    // Reset during FILL: line 0 was valid, so it must miss afterwards.
    cpuAddress = 32'h87; cpuRead = 1'b1;
    @(negedge clk);
    chk("t6.stall", stall, 1);
    chk("t6.idle_addr", memAddress, 32'h84);
    @(posedge clk); #1;
    chk("t6.fill_addr", memAddress, 32'h80);
    rst_n = 1'b0; cpuRead = 1'b0;
    #1;
    chk("t6.rst_stall", stall, 0);
    chk("t6.rst_we", memWrite, 0);
    chk("t6.rst_miss", missCount, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    lw("t6r", 32'h0, 32'h0000_5a01, 3);

    // Reset during WRITE drops the strobe at once.
    cpuAddress = 32'h10; cpuWriteData = 32'h5555_aaaa; cpuWrite = 1'b1;
    @(posedge clk); #1;
    chk("t7.we", memWrite, 1);
    rst_n = 1'b0; cpuWrite = 1'b0;
    #1;
    chk("t7.rst_we", memWrite, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    lw("t7r", 32'hc, 32'hdead_beef, 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
